// File: rtl/hybrid_seq_pkg.sv
// Shared definitions for the hybrid theta/phi angle sequencer: state codes,
// sigma encodings and the clamp/step arithmetic helpers.
package hybrid_seq_pkg;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_PENDING = 2'b01;
  localparam logic [1:0] ST_APPLY   = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    PENDING = ST_PENDING,
    APPLY   = ST_APPLY
  } state_t;

  typedef enum logic [1:0] {
    SIG_ZERO = 2'b00,
    SIG_POS  = 2'b01,
    SIG_NEG  = 2'b11
  } sigma_t;

  // Limit x to [lo, hi]; compared in 33 bits so no operand can wrap.
  function automatic logic signed [31:0] clamp32(input logic signed [31:0] x,
                                                 input logic signed [31:0] lo,
                                                 input logic signed [31:0] hi);
    logic signed [32:0] xe;
    logic signed [32:0] loe;
    logic signed [32:0] hie;
    xe  = {x[31], x};
    loe = {lo[31], lo};
    hie = {hi[31], hi};
    if (xe < loe)      return lo;
    else if (xe > hie) return hi;
    else               return x;
  endfunction

  // Move cur toward tgt by at most step, never overshooting.
  function automatic logic signed [31:0] step32(input logic signed [31:0] cur,
                                                input logic signed [31:0] tgt,
                                                input logic signed [31:0] step);
    logic signed [32:0] diff;
    logic signed [32:0] mag;
    logic signed [32:0] lim;
    logic signed [32:0] sum;
    diff = {tgt[31], tgt} - {cur[31], cur};
    lim  = {1'b0, step};
    mag  = (diff < 33'sd0) ? -diff : diff;
    if (mag > lim) mag = lim;
    sum = (diff < 33'sd0) ? ({cur[31], cur} - mag) : ({cur[31], cur} + mag);
    return sum[31:0];
  endfunction

endpackage

// File: rtl/sigma_boundary_detect.sv
// Synchronizes the controller's sigma output and pulses for one cycle each
// time the synchronized value enters SIG_POS from any other code.
module sigma_boundary_detect (
  input  logic       i_clock,
  input  logic       i_RESET,
  input  logic [1:0] sigma,
  output logic       boundary_c
);
  import hybrid_seq_pkg::*;

  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] prev;

  // Flops reset to SIG_POS so leaving reset never produces a boundary.
  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      sync1 <= SIG_POS;
      sync2 <= SIG_POS;
      prev  <= SIG_POS;
    end else begin
      sync1 <= sigma;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign boundary_c = (sync2 == SIG_POS) && (prev != SIG_POS);

endmodule

// File: rtl/hybrid_angle_sequencer.sv
// Schedules theta/phi target updates onto switching-period boundaries.
// Define HYBRID_SEQ_RAMP_EN for step-limited slewing (one step per period).
module hybrid_angle_sequencer #(
  parameter logic signed [31:0] THETA_INIT  = 32'sd135,
  parameter logic signed [31:0] PHI_INIT    = 32'sd0,
  parameter logic signed [31:0] THETA_MIN   = 32'sd90,
  parameter logic signed [31:0] THETA_MAX   = 32'sd180,
  parameter logic signed [31:0] PHI_MAX     = 32'sd45,
  parameter logic signed [31:0] STEP_THETA  = 32'sd1,
  parameter logic signed [31:0] STEP_PHI    = 32'sd1,
  parameter logic [31:0]        TIMEOUT_CYC = 32'd100000
) (
  input  logic               i_clock,
  input  logic               i_RESET,
  input  logic [1:0]         i_sigma,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic signed [31:0] i_theta_tgt,
  input  logic signed [31:0] i_phi_tgt,
  output logic signed [31:0] o_theta,
  output logic signed [31:0] o_phi,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_timeout,
  output logic [1:0]         o_state
);
  import hybrid_seq_pkg::*;

`ifdef HYBRID_SEQ_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  localparam logic signed [31:0] PHI_MIN = -PHI_MAX;

  state_t             state_q, state_d;
  logic               boundary_c;
  logic signed [31:0] tgt_theta_q, tgt_theta_d;
  logic signed [31:0] tgt_phi_q, tgt_phi_d;
  logic signed [31:0] theta_d, phi_d;
  logic signed [31:0] theta_next_c, phi_next_c;
  logic [31:0]        cnt_q, cnt_d;
  logic               timeout_d;
  logic               done_d;

  sigma_boundary_detect u_bnd (
    .i_clock    (i_clock),
    .i_RESET    (i_RESET),
    .sigma      (i_sigma),
    .boundary_c (boundary_c)
  );

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and datapath update; the APPLY value is a full load or one step.
  always_comb begin
    state_d      = state_q;
    tgt_theta_d  = tgt_theta_q;
    tgt_phi_d    = tgt_phi_q;
    theta_d      = o_theta;
    phi_d        = o_phi;
    cnt_d        = cnt_q;
    timeout_d    = o_timeout;
    done_d       = 1'b0;
    theta_next_c = RAMP_EN ? step32(o_theta, tgt_theta_q, STEP_THETA) : tgt_theta_q;
    phi_next_c   = RAMP_EN ? step32(o_phi, tgt_phi_q, STEP_PHI) : tgt_phi_q;

    unique case (state_q)
      IDLE: begin
        if (i_req_valid && o_req_ready) begin
          tgt_theta_d = clamp32(i_theta_tgt, THETA_MIN, THETA_MAX);
          tgt_phi_d   = clamp32(i_phi_tgt, PHI_MIN, PHI_MAX);
          cnt_d       = '0;
          timeout_d   = 1'b0;
          state_d     = PENDING;
        end
      end
      PENDING: begin
        if (boundary_c) begin
          state_d = APPLY;
        end else if (cnt_q == TIMEOUT_CYC - 32'd1) begin
          timeout_d = 1'b1;
          state_d   = APPLY;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      APPLY: begin
        theta_d = theta_next_c;
        phi_d   = phi_next_c;
        if ((theta_next_c == tgt_theta_q) && (phi_next_c == tgt_phi_q)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = '0;
          state_d = PENDING;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track state_q.
  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      tgt_theta_q <= THETA_INIT;
      tgt_phi_q   <= PHI_INIT;
      o_theta     <= THETA_INIT;
      o_phi       <= PHI_INIT;
      cnt_q       <= '0;
      o_timeout   <= 1'b0;
      o_done      <= 1'b0;
      o_req_ready <= 1'b1;
      o_busy      <= 1'b0;
      o_state     <= ST_IDLE;
    end else begin
      tgt_theta_q <= tgt_theta_d;
      tgt_phi_q   <= tgt_phi_d;
      o_theta     <= theta_d;
      o_phi       <= phi_d;
      cnt_q       <= cnt_d;
      o_timeout   <= timeout_d;
      o_done      <= done_d;
      o_req_ready <= (state_d == IDLE);
      o_busy      <= (state_d != IDLE);
      o_state     <= state_d;
    end
  end

endmodule

// File: tb/tb_hybrid_angle_sequencer.sv
// Randomized bench for hybrid_angle_sequencer against a period-level model
// of the scheduling rules; follows HYBRID_SEQ_RAMP_EN like the design.
module tb_hybrid_angle_sequencer;

`ifdef HYBRID_SEQ_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif
  localparam int TMO = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         sigma;
  logic               req_valid;
  logic               req_ready;
  logic signed [31:0] theta_tgt;
  logic signed [31:0] phi_tgt;
  logic signed [31:0] theta;
  logic signed [31:0] phi;
  logic               busy;
  logic               done;
  logic               timeout;
  logic [1:0]         state;

  always #5 clk = ~clk;

  hybrid_angle_sequencer #(.TIMEOUT_CYC(32'd16)) dut (
    .i_clock     (clk),
    .i_RESET     (rst_n),
    .i_sigma     (sigma),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_theta_tgt (theta_tgt),
    .i_phi_tgt   (phi_tgt),
    .o_theta     (theta),
    .o_phi       (phi),
    .o_busy      (busy),
    .o_done      (done),
    .o_timeout   (timeout),
    .o_state     (state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: boundary = sigma sampled 01 two edges ago, not 01 three edges ago.
  longint     m_theta, m_phi, m_tth, m_tph;
  bit         m_busy, m_apply, m_timeout, m_done;
  int         m_wait;
  logic [1:0] h [3];

  function automatic longint clampv(input longint x, input longint lo, input longint hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  function automatic longint stepv(input longint cur, input longint tgt, input longint st);
    if (tgt - cur > st)  return cur + st;
    if (tgt - cur < -st) return cur - st;
    return tgt;
  endfunction

  task automatic model_reset();
    m_theta = 135; m_phi = 0; m_tth = 135; m_tph = 0;
    m_busy = 0; m_apply = 0; m_timeout = 0; m_done = 0; m_wait = 0;
    for (int i = 0; i < 3; i++) h[i] = 2'b01;
  endtask

  task automatic model_edge(input bit v, input longint th, input longint ph, input logic [1:0] s);
    bit bnd;
    bnd    = (h[1] == 2'b01) && (h[2] != 2'b01);
    m_done = 0;
    if (m_apply) begin
      m_apply = 0;
      if (RAMP) begin
        m_theta = stepv(m_theta, m_tth, 1);
        m_phi   = stepv(m_phi, m_tph, 1);
      end else begin
        m_theta = m_tth;
        m_phi   = m_tph;
      end
      if (m_theta == m_tth && m_phi == m_tph) begin
        m_done = 1;
        m_busy = 0;
      end else begin
        m_wait = 0;
      end
    end else if (m_busy) begin
      if (bnd) m_apply = 1;
      else if (m_wait == TMO - 1) begin
        m_timeout = 1;
        m_apply   = 1;
      end else m_wait++;
    end else if (v) begin
      m_tth = clampv(th, 90, 180);
      m_tph = clampv(ph, -45, 45);
      m_busy = 1; m_wait = 0; m_timeout = 0;
    end
    h[2] = h[1]; h[1] = h[0]; h[0] = s;
  endtask

  task automatic compare_all();
    check_eq("theta", theta, m_theta);
    check_eq("phi", phi, m_phi);
    check_eq("busy", busy, m_busy);
    check_eq("ready", req_ready, !m_busy);
    check_eq("done", done, m_done);
    check_eq("timeout", timeout, m_timeout);
    check_eq("state", state, m_busy ? (m_apply ? 2 : 1) : 0);
  endtask

  // Called at a negedge: drive, let one rising edge pass, then compare.
  task automatic cycle(input bit v, input longint th, input longint ph, input logic [1:0] s);
    req_valid = v;
    theta_tgt = 32'(th);
    phi_tgt   = 32'(ph);
    sigma     = s;
    @(posedge clk);
    model_edge(v, th, ph, s);
    @(negedge clk);
    compare_all();
  endtask

  logic [1:0] pat [4];
  int         pat_idx = 0;
  logic [1:0] rs_cur  = 2'b00;
  int         rs_left = 0;

  // mode 0: 01,00,11,00 two cycles each; 1: hold 00; 2: random holds.
  task automatic next_sigma(input int mode, output logic [1:0] s);
    int r;
    if (mode == 0) begin
      s = pat[(pat_idx / 2) % 4];
      pat_idx++;
    end else if (mode == 1) begin
      s = 2'b00;
    end else begin
      if (rs_left == 0) begin
        r = int'($urandom_range(0, 9));
        rs_cur  = (r < 4) ? 2'b01 : (r < 7) ? 2'b00 : (r < 9) ? 2'b11 : 2'b10;
        rs_left = ($urandom_range(0, 19) == 0) ? 25 : int'($urandom_range(1, 5));
      end
      s = rs_cur;
      rs_left--;
    end
  endtask

  task automatic request(input longint th, input longint ph, input int mode);
    logic [1:0] s;
    next_sigma(mode, s);
    cycle(1'b1, th, ph, s);
  endtask

  task automatic run_until_idle(input string tag, input int budget, input int mode);
    logic [1:0] s;
    int i;
    for (i = 0; i < budget; i++) begin
      if (!m_busy) break;
      next_sigma(mode, s);
      cycle(1'b0, 0, 0, s);
    end
    check_eq({tag, "_ready"}, req_ready, 1);
  endtask

  task automatic idle_cycles(input int n, input logic [1:0] s);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] s;
    longint     held;
    pat[0] = 2'b01; pat[1] = 2'b00; pat[2] = 2'b11; pat[3] = 2'b00;
    rst_n = 1'b0; req_valid = 1'b0; sigma = 2'b00; theta_tgt = '0; phi_tgt = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_theta", theta, 135);
    check_eq("rst_phi", phi, 0);
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_state", state, 0);
    idle_cycles(3, 2'b00);

    // Nominal request; ramp mode walks one degree per period.
    pat_idx = 0;
    request(150, 10, 0);
    run_until_idle("ramp", 1000, 0);
    check_eq("ramp_theta", theta, 150);
    check_eq("ramp_phi", phi, 10);

    // Out-of-range request clamps to the safe corner.
    request(200, -60, 0);
    run_until_idle("clamp", 1000, 0);
    check_eq("clamp_theta", theta, 180);
    check_eq("clamp_phi", phi, -45);

    // No switching: forced apply by timeout, flag cleared on next accept.
    idle_cycles(4, 2'b00);
    request(175, -40, 1);
    run_until_idle("tmo", 1000, 1);
    check_eq("tmo_flag", timeout, 1);
    check_eq("tmo_theta", theta, 175);
    pat_idx = 0;
    request(160, 0, 0);
    check_eq("tmo_clear", timeout, 0);
    run_until_idle("tmo2", 1000, 0);

    // Accept coincides with a boundary pulse: that boundary must be skipped.
    idle_cycles(4, 2'b00);
    cycle(1'b0, 0, 0, 2'b01);
    cycle(1'b0, 0, 0, 2'b01);
    cycle(1'b1, 120, -5, 2'b01);
    held = m_theta;
    idle_cycles(6, 2'b01);
    check_eq("simul_hold", theta, held);
    pat_idx = 0;
    run_until_idle("simul", 1000, 0);

    // Reset while an update is in progress.
    pat_idx = 0;
    request(170, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if (RAMP ? (m_theta == 142) : (i >= 3)) break;
      next_sigma(0, s);
      cycle(1'b0, 0, 0, s);
    end
    if (RAMP) check_eq("midramp_theta", theta, 142);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_theta", theta, 135);
    check_eq("arst_phi", phi, 0);
    check_eq("arst_state", state, 0);
    check_eq("arst_ready", req_ready, 1);
    check_eq("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2, 2'b00);

    // Random traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      next_sigma(2, s);
      cycle($urandom_range(0, 3) == 0, longint'($urandom_range(60, 220)),
            longint'($urandom_range(0, 140)) - 70, s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
